// File: rtl/codec_pkg.sv
// Shared defaults and frame sizing for the codec sample path.
package codec_pkg;

    localparam int CODEC_WIDTH      = 16;
    localparam int CODEC_CHANNELS   = 2;
    localparam int CODEC_FIFO_DEPTH = 4;

    function automatic int frame_width(input int width, input int channels);
        return width * channels;
    endfunction

endpackage

// File: rtl/frame_fifo.sv
// Frame FIFO with wrap-bit pointers; the head is exposed combinationally so
// the codec side can take a frame in the same cycle it asks for one.
module frame_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level
);

    logic [AW:0]       wptr, rptr;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end

    // Contents need no reset: pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rptr[AW-1:0]];
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level   = wptr - rptr;

endmodule

// File: rtl/codec_frame_buffer.sv
// Frame buffer between synthesis logic and the AC97 codec interface.
// Optional underrun counter port: define CODEC_UNDERRUN_COUNT_EN.
module codec_frame_buffer
    import codec_pkg::*;
#(
    parameter int WIDTH    = CODEC_WIDTH,
    parameter int CHANNELS = CODEC_CHANNELS,
    parameter int DEPTH    = CODEC_FIFO_DEPTH,
    localparam int FW      = frame_width(WIDTH, CHANNELS),
    localparam int LW      = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [FW-1:0] new_sample_in,
    input  logic          latch_new_sample_in,
    output logic          generate_next_sample,
    input  logic          new_frame,
    output logic [FW-1:0] valid_sample,
    output logic [LW-1:0] fill_level,
    output logic          underrun,
    output logic          overflow
`ifdef CODEC_UNDERRUN_COUNT_EN
    ,
    output logic [15:0]   underrun_count
`endif
);

    logic          prev_nf, frame_edge, pop, under_ev, wr_en, drop;
    logic          full, empty, armed, prime_q;
    logic [FW-1:0] head, cur_frame;
    logic [LW:0]   lvl_nxt;

    frame_fifo #(.DATA_W(FW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (new_sample_in),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (fill_level)
    );

    // Gated by reset so nothing leaks out while reset is held with new_frame high.
    assign frame_edge = new_frame & ~prev_nf & ~reset;
    assign pop        = frame_edge & ~empty;
    assign under_ev   = frame_edge & empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
    assign wr_en      = latch_new_sample_in & (~full | pop);
    assign drop       = latch_new_sample_in & full & ~pop;
    assign lvl_nxt    = {1'b0, fill_level} + (LW+1)'(wr_en) - (LW+1)'(pop);

    assign valid_sample         = pop ? head : cur_frame;
    assign generate_next_sample = prime_q | (frame_edge & (lvl_nxt < (LW+1)'(DEPTH)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_nf   <= 1'b0;
            cur_frame <= '0;
            armed     <= 1'b1;
            prime_q   <= 1'b0;
            underrun  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            prev_nf <= new_frame;
            armed   <= 1'b0;
            prime_q <= armed;
            if (pop)      cur_frame <= head;
            if (under_ev) underrun  <= 1'b1;
            if (drop)     overflow  <= 1'b1;
        end
    end

`ifdef CODEC_UNDERRUN_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            underrun_count <= '0;
        else if (under_ev && underrun_count != 16'hFFFF)
            underrun_count <= underrun_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_codec_frame_buffer.sv
// Randomised and directed bench for codec_frame_buffer against a queue model.
module tb_codec_frame_buffer;

    localparam int WIDTH = 16, CHANNELS = 2, DEPTH = 4;
    localparam int FW = WIDTH * CHANNELS;
    localparam int LW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [FW-1:0] din = '0;
    logic          latch = 1'b0;
    logic          new_frame = 1'b0;
    logic          gen;
    logic [FW-1:0] valid_sample;
    logic [LW-1:0] fill_level;
    logic          underrun, overflow;
    logic [15:0]   ucnt_obs;

    codec_frame_buffer #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .reset                (reset),
        .new_sample_in        (din),
        .latch_new_sample_in  (latch),
        .generate_next_sample (gen),
        .new_frame            (new_frame),
        .valid_sample         (valid_sample),
        .fill_level           (fill_level),
        .underrun             (underrun),
        .overflow             (overflow)
`ifdef CODEC_UNDERRUN_COUNT_EN
        ,
        .underrun_count       (ucnt_obs)
`endif
    );
`ifndef CODEC_UNDERRUN_COUNT_EN
    assign ucnt_obs = 16'd0;
`endif

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Reference model: a queue of frames plus the last frame handed out.
    logic [FW-1:0] m_q[$];
    logic [FW-1:0] m_cur;
    bit            m_prev, m_under, m_over, m_arm, m_prime;
    int            m_ucnt;

    logic [FW-1:0] obs_valid, exp_valid;
    logic [LW-1:0] obs_level, exp_level;
    logic          obs_gen, exp_gen, obs_under, exp_under, obs_over, exp_over;
    logic [15:0]   obs_ucnt, exp_ucnt;
    bit            last_edge;

    task automatic do_reset();
        reset = 1'b1; latch = 1'b0; new_frame = 1'b0; din = '0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        m_q.delete(); m_cur = '0; m_prev = 0; m_under = 0; m_over = 0;
        m_ucnt = 0; m_arm = 1; m_prime = 0;
    endtask

    // One clock cycle: drive, sample mid-cycle, then advance the model.
    task automatic step(input bit wr, input logic [FW-1:0] d, input bit nf);
        bit e, pop, acc;
        int after;
        latch = wr; din = d; new_frame = nf;
        #3;
        e     = nf && !m_prev;
        pop   = e && (m_q.size() > 0);
        acc   = wr && ((m_q.size() < DEPTH) || pop);
        after = m_q.size() + int'(acc) - int'(pop);
        exp_valid = pop ? m_q[0] : m_cur;
        exp_gen   = (e && after < DEPTH) || m_prime;
        exp_level = LW'(m_q.size());
        exp_under = m_under;
        exp_over  = m_over;
`ifdef CODEC_UNDERRUN_COUNT_EN
        exp_ucnt  = 16'(m_ucnt);
`else
        exp_ucnt  = 16'd0;
`endif
        obs_valid = valid_sample; obs_gen = gen; obs_level = fill_level;
        obs_under = underrun; obs_over = overflow; obs_ucnt = ucnt_obs;
        last_edge = e;
        @(posedge clk);
        if (pop) m_cur = m_q.pop_front();
        if (e && !pop) begin
            m_under = 1;
            if (m_ucnt < 16'hFFFF) m_ucnt++;
        end
        if (wr && !acc) m_over = 1;
        if (acc) m_q.push_back(d);
        m_prev  = nf;
        m_prime = m_arm;
        m_arm   = 0;
        #1;
    endtask

    task automatic test_reset();
        int pulses = 0;
        reset = 1'b1; new_frame = 1'b1; #1;
        checks++; if (valid_sample !== '0) begin errors++; $display("FAIL reset_valid got %h want 0", valid_sample); end
        checks++; if (gen !== 1'b0) begin errors++; $display("FAIL reset_gen got %b want 0", gen); end
        checks++; if ({fill_level, underrun, overflow} !== '0) begin errors++; $display("FAIL reset_state got %b want 0", {fill_level, underrun, overflow}); end
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, '0, 0);
            pulses += int'(obs_gen);
            checks++; if (obs_gen !== exp_gen) begin errors++; $display("FAIL prime_gen cyc %0d got %b want %b", i, obs_gen, exp_gen); end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL prime_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_prime_pop();
        do_reset();
        step(0, '0, 0); step(0, '0, 0);
        step(1, 32'h1111_2222, 0);
        step(0, '0, 1);
        checks++; if (obs_valid !== 32'h1111_2222) begin errors++; $display("FAIL pop_valid got %h want 11112222", obs_valid); end
        checks++; if (obs_level !== LW'(1)) begin errors++; $display("FAIL pop_level_before got %0d want 1", obs_level); end
        checks++; if (obs_gen !== 1'b1) begin errors++; $display("FAIL pop_gen got %b want 1", obs_gen); end
        for (int i = 0; i < 255; i++) begin
            step(0, '0, 1);
            checks++; if (obs_valid !== 32'h1111_2222 || obs_level !== '0 || obs_gen !== 1'b0) begin
                errors++; $display("FAIL hold_high cyc %0d got %h/%0d/%b want 11112222/0/0", i, obs_valid, obs_level, obs_gen);
            end
        end
        step(0, '0, 0);
    endtask

    task automatic test_order_wrap();
        logic [FW-1:0] got[$];
        logic [FW-1:0] want[6];
        want = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE, 32'hF};
        do_reset();
        step(0, '0, 0); step(0, '0, 0);
        for (int i = 0; i < 4; i++) step(1, want[i], 0);
        for (int i = 0; i < 2; i++) begin step(0, '0, 1); got.push_back(obs_valid); step(0, '0, 0); end
        step(1, want[4], 0); step(1, want[5], 0);
        for (int i = 0; i < 4; i++) begin step(0, '0, 1); got.push_back(obs_valid); step(0, '0, 0); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (got[i] !== want[i]) begin errors++; $display("FAIL order idx %0d got %h want %h", i, got[i], want[i]); end
        end
        checks++; if (obs_over !== 1'b0) begin errors++; $display("FAIL order_overflow got %b want 0", obs_over); end
    endtask

    task automatic test_overflow();
        logic [FW-1:0] got[$];
        do_reset();
        step(0, '0, 0); step(0, '0, 0);
        for (int i = 0; i < 5; i++) step(1, 32'hF0 + FW'(i), 0);
        step(0, '0, 0);
        checks++; if (obs_level !== LW'(4)) begin errors++; $display("FAIL ovf_level got %0d want 4", obs_level); end
        checks++; if (obs_over !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", obs_over); end
        step(1, 32'h99, 1);
        got.push_back(obs_valid);
        step(0, '0, 0);
        checks++; if (obs_level !== LW'(4) || obs_over !== 1'b1) begin errors++; $display("FAIL ovf_full_wr_pop got %0d/%b want 4/1", obs_level, obs_over); end
        for (int i = 0; i < 4; i++) begin step(0, '0, 1); got.push_back(obs_valid); step(0, '0, 0); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (got[i] !== (i < 4 ? 32'hF0 + FW'(i) : 32'h99)) begin
                errors++; $display("FAIL ovf_order idx %0d got %h want %h", i, got[i], (i < 4 ? 32'hF0 + FW'(i) : 32'h99));
            end
        end
    endtask

    task automatic test_underrun();
        do_reset();
        step(0, '0, 0); step(0, '0, 0);
        step(1, 32'hCAFE_0001, 0);
        step(0, '0, 1); step(0, '0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 1);
            checks++; if (obs_valid !== 32'hCAFE_0001 || obs_gen !== exp_gen) begin
                errors++; $display("FAIL underrun_repeat %0d got %h/%b want cafe0001/%b", i, obs_valid, obs_gen, exp_gen);
            end
            step(0, '0, 0);
        end
        checks++; if (obs_under !== 1'b1) begin errors++; $display("FAIL underrun_flag got %b want 1", obs_under); end
`ifdef CODEC_UNDERRUN_COUNT_EN
        checks++; if (obs_ucnt !== 16'd3) begin errors++; $display("FAIL underrun_count got %0d want 3", obs_ucnt); end
`endif
    endtask

    task automatic test_simul();
        do_reset();
        step(0, '0, 0); step(0, '0, 0);
        step(1, 32'h5555_AAAA, 1);
        checks++; if (obs_valid !== '0) begin errors++; $display("FAIL simul_valid got %h want 0", obs_valid); end
        step(0, '0, 0);
        checks++; if (obs_under !== 1'b1 || obs_level !== LW'(1)) begin errors++; $display("FAIL simul_state got %b/%0d want 1/1", obs_under, obs_level); end
        step(0, '0, 1);
        checks++; if (obs_valid !== 32'h5555_AAAA) begin errors++; $display("FAIL simul_next got %h want 5555aaaa", obs_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(0, '0, 0); step(0, '0, 0);
        for (int i = 0; i < 5; i++) step(1, 32'h700 + FW'(i), 0);
        step(0, '0, 1);
        step(0, '0, 1);
        #2 reset = 1'b1;
        #1;
        checks++; if ({valid_sample, fill_level, gen, underrun, overflow} !== '0) begin
            errors++; $display("FAIL async_reset got %h/%0d/%b/%b/%b want all 0", valid_sample, fill_level, gen, underrun, overflow);
        end
        do_reset();
        step(0, '0, 0); step(0, '0, 0);
        step(0, '0, 1);
        checks++; if (obs_valid !== '0) begin errors++; $display("FAIL async_after_valid got %h want 0", obs_valid); end
        step(0, '0, 0);
        checks++; if (obs_under !== 1'b1 || obs_level !== '0) begin errors++; $display("FAIL async_after_under got %b/%0d want 1/0", obs_under, obs_level); end
    endtask

    task automatic test_random();
        bit nf = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) nf = !nf;
            step(bit'($urandom_range(0, 99) < 45), FW'($urandom), nf);
            checks++; if (obs_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %h want %h", i, obs_valid, exp_valid); end
            checks++; if (obs_gen !== exp_gen) begin errors++; $display("FAIL rnd_gen cyc %0d got %b want %b", i, obs_gen, exp_gen); end
            checks++; if (obs_level !== exp_level) begin errors++; $display("FAIL rnd_level cyc %0d got %0d want %0d", i, obs_level, exp_level); end
            checks++; if ({obs_under, obs_over} !== {exp_under, exp_over}) begin
                errors++; $display("FAIL rnd_flags cyc %0d got %b%b want %b%b", i, obs_under, obs_over, exp_under, exp_over);
            end
            checks++; if (obs_ucnt !== exp_ucnt) begin errors++; $display("FAIL rnd_ucnt cyc %0d got %0d want %0d", i, obs_ucnt, exp_ucnt); end
        end
    endtask

    initial begin
        test_reset();
        test_prime_pop();
        test_order_wrap();
        test_overflow();
        test_underrun();
        test_simul();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
